// File: rtl/inv_drive_sequencer_pkg.sv
// rtl/inv_drive_sequencer_pkg.sv - shared states, fault codes and timing defaults for the inverter sequencer
package inv_drive_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLOSE = 3'd1,
    ST_ARM   = 3'd2,
    ST_RUN   = 3'd3,
    ST_STOP  = 3'd4,
    ST_FAULT = 3'd5
  } state_t;

  localparam logic [2:0] FAULT_NONE     = 3'd0;
  localparam logic [2:0] FAULT_SO1      = 3'd1;
  localparam logic [2:0] FAULT_SO2      = 3'd2;
  localparam logic [2:0] FAULT_SO3      = 3'd3;
  localparam logic [2:0] FAULT_OTEMP    = 3'd4;
  localparam logic [2:0] FAULT_PWM_LOSS = 3'd5;
  localparam logic [2:0] FAULT_SHOOT    = 3'd6;

  localparam int CONTACT_CYC_DEF  = 500000;
  localparam int ENABLE_CYC_DEF   = 500;
  localparam int PWM_LOSS_CYC_DEF = 50000;
  localparam int DEADTIME_CYC_DEF = 50;

  localparam int STATE_CNT_W = 19;
  localparam int LOSS_CNT_W  = 17;

  // Lowest code wins when several faults are present in the same cycle.
  function automatic logic [2:0] first_fault(input logic [2:0] so, input logic otemp,
                                             input logic loss, input logic shoot);
    logic [2:0] code;
    code = FAULT_NONE;
    if (so[0])      code = FAULT_SO1;
    else if (so[1]) code = FAULT_SO2;
    else if (so[2]) code = FAULT_SO3;
    else if (otemp) code = FAULT_OTEMP;
    else if (loss)  code = FAULT_PWM_LOSS;
    else if (shoot) code = FAULT_SHOOT;
    return code;
  endfunction

endpackage

// File: rtl/inv_leg_interlock.sv
// rtl/inv_leg_interlock.sv - dead-time interlock for one complementary bridge leg
module inv_leg_interlock
  import inv_drive_sequencer_pkg::*;
#(
  parameter int DEADTIME_CYC = DEADTIME_CYC_DEF
) (
  input  logic CLK0,
  input  logic RST,
  input  logic a,
  input  logic b,
  output logic ga,
  output logic gb,
  output logic shoot
);

  localparam int CW = (DEADTIME_CYC < 1) ? 1 : $clog2(DEADTIME_CYC + 1);
  localparam logic [CW-1:0] DT = CW'(DEADTIME_CYC);

  logic [CW-1:0] cnt_a;
  logic [CW-1:0] cnt_b;

  // A side is released only once its input has been high, with the other side quiet, for DT cycles.
  always_comb begin
    shoot = a & b;
    ga    = a & ~b & (cnt_a == DT);
    gb    = b & ~a & (cnt_b == DT);
  end

  always_ff @(posedge CLK0) begin
    if (RST) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (!a || b || gb)   cnt_a <= '0;
      else if (cnt_a != DT) cnt_a <= cnt_a + 1'b1;
      if (!b || a || ga)   cnt_b <= '0;
      else if (cnt_b != DT) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: rtl/inv_drive_sequencer.sv
// rtl/inv_drive_sequencer.sv - start/stop/fault sequencer for one inverter bridge
module inv_drive_sequencer
  import inv_drive_sequencer_pkg::*;
#(
  parameter int CONTACT_CYC  = CONTACT_CYC_DEF,
  parameter int ENABLE_CYC   = ENABLE_CYC_DEF,
  parameter int PWM_LOSS_CYC = PWM_LOSS_CYC_DEF,
  parameter int DEADTIME_CYC = DEADTIME_CYC_DEF
) (
  input  logic       CLK0,
  input  logic       RST,
  input  logic       CMD_START,
  input  logic       CMD_STOP,
  input  logic       CMD_CLR,
  input  logic [5:0] PWM,
  input  logic [2:0] SO,
  input  logic       WG1,
  input  logic       BP_ON,
  output logic [5:0] DR,
  output logic       ENABLE,
  output logic       TRIP1,
  output logic       CONTACTOR,
  output logic [2:0] STATE,
  output logic [2:0] FAULT_CODE,
  output logic       BYP_REQ,
  output logic       FAULT_IRQ
);

  localparam logic [STATE_CNT_W-1:0] CONTACT_LAST = STATE_CNT_W'(CONTACT_CYC - 1);
  localparam logic [STATE_CNT_W-1:0] ENABLE_LAST  = STATE_CNT_W'(ENABLE_CYC - 1);
  localparam logic [STATE_CNT_W-1:0] ENABLE_HOLD  = STATE_CNT_W'(ENABLE_CYC);
  localparam logic [LOSS_CNT_W-1:0]  LOSS_LIMIT   = LOSS_CNT_W'(PWM_LOSS_CYC);

  logic [5:0] pwm_m, pwm_s, pwm_prev;
  logic [2:0] so_m, so_s;
  logic       wg1_m, wg1_s;
  logic       bp_m, bp_s;

  state_t                 state, next_state;
  logic [STATE_CNT_W-1:0] state_cnt, state_cnt_d;
  logic [LOSS_CNT_W-1:0]  loss_cnt, loss_cnt_d;

  logic [5:0] gate;
  logic [2:0] shoot;
  logic       in_run;
  logic       pwm_loss;
  logic [2:0] fault_now;
  logic       fault_active;
  logic       byp_set;

  logic [5:0] dr_d;
  logic       enable_d;
  logic       contactor_d;
  logic       trip_d;

  for (genvar i = 0; i < 3; i++) begin : g_leg
    inv_leg_interlock #(.DEADTIME_CYC(DEADTIME_CYC)) u_leg (
      .CLK0  (CLK0),
      .RST   (RST),
      .a     (pwm_s[2*i]),
      .b     (pwm_s[2*i+1]),
      .ga    (gate[2*i]),
      .gb    (gate[2*i+1]),
      .shoot (shoot[i])
    );
  end

  // PWM loss and shoot-through only mean something while the bridge is switching.
  always_comb begin
    in_run       = (state == ST_RUN);
    pwm_loss     = in_run && (loss_cnt >= LOSS_LIMIT);
    fault_now    = first_fault(so_s, ~wg1_s, pwm_loss, in_run && (|shoot));
    fault_active = (fault_now != FAULT_NONE);
    loss_cnt_d   = '0;
    if (in_run && (pwm_s == pwm_prev))
      loss_cnt_d = (loss_cnt == '1) ? loss_cnt : loss_cnt + 1'b1;
  end

  always_comb begin
    next_state = state;
    byp_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fault_active)                 next_state = ST_FAULT;
        else if (CMD_START && !CMD_STOP)  next_state = ST_CLOSE;
      end
      ST_CLOSE: begin
        if (fault_active)                 next_state = ST_FAULT;
        else if (CMD_STOP)                next_state = ST_STOP;
        else if (state_cnt == CONTACT_LAST) next_state = ST_ARM;
      end
      ST_ARM: begin
        if (fault_active)                 next_state = ST_FAULT;
        else if (CMD_STOP)                next_state = ST_STOP;
        else if (state_cnt == ENABLE_LAST) next_state = ST_RUN;
      end
      ST_RUN: begin
        if (fault_active)                 next_state = ST_FAULT;
        else if (CMD_STOP || !bp_s) begin
          next_state = ST_STOP;
          byp_set    = !bp_s;
        end
      end
      ST_STOP: begin
        if (fault_active)                 next_state = ST_FAULT;
        else if (state_cnt >= ENABLE_HOLD) next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (CMD_CLR && !fault_active)     next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they register on the same edge as the state.
  always_comb begin
    state_cnt_d = '0;
    if (next_state == state)
      state_cnt_d = (state_cnt == '1) ? state_cnt : state_cnt + 1'b1;
    dr_d        = '0;
    enable_d    = 1'b1;
    contactor_d = 1'b0;
    trip_d      = 1'b0;
    case (next_state)
      ST_CLOSE: contactor_d = 1'b1;
      ST_ARM: begin
        contactor_d = 1'b1;
        enable_d    = 1'b0;
      end
      ST_RUN: begin
        contactor_d = 1'b1;
        enable_d    = 1'b0;
        dr_d        = gate;
      end
      ST_STOP: begin
        contactor_d = 1'b1;
        enable_d    = ENABLE || (state_cnt_d >= ENABLE_HOLD);
      end
      ST_FAULT: trip_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK0) begin
    if (RST) begin
      pwm_m      <= '0;
      pwm_s      <= '0;
      pwm_prev   <= '0;
      so_m       <= '0;
      so_s       <= '0;
      wg1_m      <= 1'b1;
      wg1_s      <= 1'b1;
      bp_m       <= 1'b1;
      bp_s       <= 1'b1;
      state      <= ST_IDLE;
      state_cnt  <= '0;
      loss_cnt   <= '0;
      DR         <= '0;
      ENABLE     <= 1'b1;
      TRIP1      <= 1'b0;
      CONTACTOR  <= 1'b0;
      FAULT_CODE <= FAULT_NONE;
      BYP_REQ    <= 1'b0;
      FAULT_IRQ  <= 1'b0;
    end else begin
      pwm_m     <= PWM;
      pwm_s     <= pwm_m;
      pwm_prev  <= pwm_s;
      so_m      <= SO;
      so_s      <= so_m;
      wg1_m     <= WG1;
      wg1_s     <= wg1_m;
      bp_m      <= BP_ON;
      bp_s      <= bp_m;
      state     <= next_state;
      state_cnt <= state_cnt_d;
      loss_cnt  <= loss_cnt_d;
      DR        <= dr_d;
      ENABLE    <= enable_d;
      TRIP1     <= trip_d;
      CONTACTOR <= contactor_d;
      FAULT_IRQ <= (next_state == ST_FAULT) && (state != ST_FAULT);
      if ((next_state == ST_FAULT) && (state != ST_FAULT))
        FAULT_CODE <= fault_now;
      else if ((state == ST_FAULT) && (next_state == ST_IDLE))
        FAULT_CODE <= FAULT_NONE;
      if (byp_set)      BYP_REQ <= 1'b1;
      else if (CMD_CLR) BYP_REQ <= 1'b0;
    end
  end

  assign STATE = state;

endmodule

// File: tb/tb_inv_drive_sequencer.sv
// tb/tb_inv_drive_sequencer.sv - directed self-checking bench for inv_drive_sequencer
module tb_inv_drive_sequencer;

  localparam int C = 40;
  localparam int E = 10;
  localparam int L = 60;
  localparam int D = 5;

  logic       clk0 = 1'b0;
  logic       rst;
  logic       cmd_start, cmd_stop, cmd_clr;
  logic [5:0] pwm;
  logic [2:0] so;
  logic       wg1, bp_on;
  logic [5:0] dr;
  logic       enable, trip1, contactor, byp_req, fault_irq;
  logic [2:0] state, fault_code;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  inv_drive_sequencer #(
    .CONTACT_CYC  (C),
    .ENABLE_CYC   (E),
    .PWM_LOSS_CYC (L),
    .DEADTIME_CYC (D)
  ) dut (
    .CLK0       (clk0),
    .RST        (rst),
    .CMD_START  (cmd_start),
    .CMD_STOP   (cmd_stop),
    .CMD_CLR    (cmd_clr),
    .PWM        (pwm),
    .SO         (so),
    .WG1        (wg1),
    .BP_ON      (bp_on),
    .DR         (dr),
    .ENABLE     (enable),
    .TRIP1      (trip1),
    .CONTACTOR  (contactor),
    .STATE      (state),
    .FAULT_CODE (fault_code),
    .BYP_REQ    (byp_req),
    .FAULT_IRQ  (fault_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk0);
  endtask

  task automatic pulse_clr();
    cmd_clr = 1'b1;
    step(1);
    cmd_clr = 1'b0;
  endtask

  task automatic go_run();
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    check("close_state", 32'(state), 1);
    check("contactor_on", 32'(contactor), 1);
    step(C - 1);
    check("arm_not_yet", 32'(enable), 1);
    step(1);
    check("arm_enable", 32'(enable), 0);
    check("arm_state", 32'(state), 2);
    step(E - 1);
    check("run_not_yet", 32'(state), 2);
    step(1);
    check("run_state", 32'(state), 3);
  endtask

  initial begin
    rst = 1'b1;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clr = 1'b0;
    pwm = 6'b0; so = 3'b0; wg1 = 1'b1; bp_on = 1'b1;
    step(3);
    check("rst_dr", 32'(dr), 0);
    check("rst_enable", 32'(enable), 1);
    check("rst_trip", 32'(trip1), 0);
    check("rst_contactor", 32'(contactor), 0);
    check("rst_state", 32'(state), 0);
    check("rst_code", 32'(fault_code), 0);
    check("rst_byp", 32'(byp_req), 0);
    check("rst_irq", 32'(fault_irq), 0);
    rst = 1'b0;
    step(2);

    // startup, then dead-time and shoot-through
    pwm = 6'b000001;
    go_run();
    check("run_dr_follow", 32'(dr), 'h01);
    pwm = 6'b000100;
    step(2);
    check("dr_old_held", 32'(dr), 'h01);
    step(1);
    check("dr_fall_next", 32'(dr), 'h00);
    step(D - 1);
    check("dr_deadtime_wait", 32'(dr), 'h00);
    step(1);
    check("dr_deadtime_rise", 32'(dr), 'h04);
    pwm = 6'b000011;
    step(2);
    check("shoot_not_yet", 32'(state), 3);
    check("shoot_irq_low", 32'(fault_irq), 0);
    step(1);
    check("shoot_state", 32'(state), 5);
    check("shoot_dr", 32'(dr), 0);
    check("shoot_code", 32'(fault_code), 6);
    check("shoot_irq", 32'(fault_irq), 1);
    check("shoot_trip", 32'(trip1), 1);
    check("shoot_enable", 32'(enable), 1);
    check("shoot_contactor", 32'(contactor), 0);
    step(1);
    check("shoot_irq_once", 32'(fault_irq), 0);
    check("shoot_code_held", 32'(fault_code), 6);
    pwm = 6'b000000;
    pulse_clr();
    check("clr_idle", 32'(state), 0);
    check("clr_code", 32'(fault_code), 0);
    check("clr_trip", 32'(trip1), 0);

    // simultaneous desat and over-temp
    pwm = 6'b000001;
    step(2);
    go_run();
    so = 3'b010; wg1 = 1'b0;
    step(2);
    check("desat_dr_held", 32'(dr), 'h01);
    step(1);
    check("desat_dr_off", 32'(dr), 0);
    check("desat_trip", 32'(trip1), 1);
    check("desat_code", 32'(fault_code), 2);
    pulse_clr();
    check("clr_ignored_state", 32'(state), 5);
    check("clr_ignored_code", 32'(fault_code), 2);
    so = 3'b000; wg1 = 1'b1;
    step(3);
    pulse_clr();
    check("desat_clr_idle", 32'(state), 0);
    check("desat_clr_code", 32'(fault_code), 0);

    // PWM loss with constant PWM
    go_run();
    step(L);
    check("loss_not_yet", 32'(state), 3);
    step(1);
    check("loss_state", 32'(state), 5);
    check("loss_code", 32'(fault_code), 5);
    pulse_clr();
    check("loss_clr_idle", 32'(state), 0);

    // PWM toggling just inside the loss window, then START+STOP together
    go_run();
    for (int i = 0; i < 5; i++) begin
      pwm = pwm ^ 6'b000001;
      step(L - 1);
    end
    check("toggle_no_fault_state", 32'(state), 3);
    check("toggle_no_fault_code", 32'(fault_code), 0);
    cmd_start = 1'b1; cmd_stop = 1'b1;
    step(1);
    cmd_start = 1'b0; cmd_stop = 1'b0;
    check("stop_state", 32'(state), 4);
    check("stop_dr", 32'(dr), 0);
    check("stop_enable_held", 32'(enable), 0);
    step(E - 1);
    check("stop_enable_wait", 32'(enable), 0);
    step(1);
    check("stop_enable_off", 32'(enable), 1);
    check("stop_contactor_held", 32'(contactor), 1);
    step(1);
    check("stop_contactor_off", 32'(contactor), 0);
    check("stop_idle", 32'(state), 0);

    // bypass request
    go_run();
    bp_on = 1'b0;
    step(2);
    check("byp_not_yet", 32'(state), 3);
    step(1);
    check("byp_state", 32'(state), 4);
    check("byp_flag", 32'(byp_req), 1);
    bp_on = 1'b1;
    step(E + 1);
    check("byp_idle", 32'(state), 0);
    check("byp_sticky", 32'(byp_req), 1);
    pulse_clr();
    check("byp_cleared", 32'(byp_req), 0);

    // reset during CLOSE
    cmd_start = 1'b1;
    step(1);
    cmd_start = 1'b0;
    step(3);
    check("mid_close", 32'(state), 1);
    rst = 1'b1;
    step(1);
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_contactor", 32'(contactor), 0);
    check("mid_rst_enable", 32'(enable), 1);
    check("mid_rst_dr", 32'(dr), 0);
    rst = 1'b0;
    step(2);

    // fault in IDLE, desat outranks over-temp
    so = 3'b100; wg1 = 1'b0;
    step(3);
    check("idle_fault_state", 32'(state), 5);
    check("idle_fault_code", 32'(fault_code), 3);
    so = 3'b000; wg1 = 1'b1;
    step(3);
    pulse_clr();
    check("idle_fault_clr", 32'(state), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
